// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES key schedule.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         WORD_W    = 32;
    localparam int         BYTE_W    = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DRAIN
    } ks_state_e;

    function automatic int nk(input int key_width);
        return key_width / WORD_W;
    endfunction

    function automatic int nr(input int key_width);
        return nk(key_width) + 6;
    endfunction

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < BYTE_W; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/s_box.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module s_box
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    output logic [BYTE_W-1:0] s_byte_out
);

    logic [BYTE_W-1:0] sq;
    logic [BYTE_W-1:0] inv;

    // inverse computed as x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0
    always_comb begin
        sq  = byte_in;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s_byte_out = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one word per cycle, round keys
// streamed out over valid/ready with backpressure.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH   = 128,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [KEY_WIDTH-1:0]   key_i,
    output logic                   busy_o,
    output logic                   rk_valid_o,
    input  logic                   rk_ready_i,
    output logic [BLOCK_WIDTH-1:0] rk_o,
    output logic [3:0]             rk_idx_o,
    output logic                   rk_last_o,
    output logic                   done_o
);

    localparam int NK = nk(KEY_WIDTH);
    localparam int NR = nr(KEY_WIDTH);
    localparam int NW = 4 * (NR + 1);
    localparam int KW = $clog2(NK);

    if (!(KEY_WIDTH == 128 || KEY_WIDTH == 192 || KEY_WIDTH == 256)) begin : g_bad_key_width
        $error("aes_key_schedule: KEY_WIDTH must be 128, 192 or 256");
    end
    if (BLOCK_WIDTH != 128) begin : g_bad_block_width
        $error("aes_key_schedule: BLOCK_WIDTH must be 128");
    end

    ks_state_e              state_q;
    word_t                  win_q [NK];
    word_t                  col_q [3];
    logic [5:0]             i_q;
    logic [KW-1:0]          kpos_q;
    logic [BYTE_W-1:0]      rcon_q;
    logic [BLOCK_WIDTH-1:0] rk_q;
    logic                   rk_valid_q;
    logic [3:0]             rk_idx_q;
    logic                   rk_last_q;
    logic                   busy_q;
    logic                   done_q;

    word_t temp;
    word_t sub_in;
    word_t sub_out;
    word_t w;
    logic  rk_fire;
    logic  stall;

    assign rk_fire = rk_valid_q & rk_ready_i;
    // slot 3 completes a round key; it cannot leave while the output is held
    assign stall   = (i_q[1:0] == 2'd3) & rk_valid_q & ~rk_ready_i;

    assign temp   = win_q[NK-1];
    assign sub_in = (kpos_q == '0) ? {temp[7:0], temp[31:8]} : temp;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        s_box u_s_box (
            .byte_in    (sub_in[BYTE_W*b +: BYTE_W]),
            .s_byte_out (sub_out[BYTE_W*b +: BYTE_W])
        );
    end

    always_comb begin
        w = win_q[0] ^ temp;
        if (i_q < 6'(NK)) begin
            w = win_q[kpos_q];
        end else if (kpos_q == '0) begin
            w = win_q[0] ^ sub_out ^ {24'h0, rcon_q};
        end else if (NK == 8 && int'(kpos_q) == 4) begin
            w = win_q[0] ^ sub_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            kpos_q  <= '0;
            rcon_q  <= RCON_INIT;
            for (int k = 0; k < NK; k++) win_q[k] <= '0;
            for (int k = 0; k < 3; k++) col_q[k] <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rk_fire) begin
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < NK; k++) win_q[k] <= key_i[WORD_W*k +: WORD_W];
                        i_q     <= '0;
                        kpos_q  <= '0;
                        rcon_q  <= RCON_INIT;
                        busy_q  <= 1'b1;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    if (!stall) begin
                        if (i_q[1:0] != 2'd3) begin
                            col_q[i_q[1:0]] <= w;
                        end else begin
                            rk_q       <= {w, col_q[2], col_q[1], col_q[0]};
                            rk_valid_q <= 1'b1;
                            rk_idx_q   <= i_q[5:2];
                            rk_last_q  <= (i_q[5:2] == 4'(NR));
                        end
                        if (i_q >= 6'(NK)) begin
                            for (int k = 0; k < NK - 1; k++) win_q[k] <= win_q[k+1];
                            win_q[NK-1] <= w;
                            if (kpos_q == '0) rcon_q <= xtime(rcon_q);
                        end
                        i_q    <= i_q + 6'd1;
                        kpos_q <= (kpos_q == KW'(NK - 1)) ? '0 : kpos_q + 1'b1;
                        if (i_q == 6'(NW - 1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // hold DRAIN through the done pulse so a start there is ignored
                    if (done_q) begin
                        state_q <= IDLE;
                    end else if (rk_fire) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_o       = rk_q;
    assign rk_idx_o   = rk_idx_q;
    assign rk_last_o  = rk_last_q;
    assign done_o     = done_q;

endmodule
